// File: rtl/dmem_arb_pkg.sv
// Shared widths, FSM state encoding and memory-request payload for the DMem arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_CLEAR = 2'd1;
  localparam arb_state_t ST_DONE  = 2'd2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug, clear-control and memory-side signals of the DMem arbiter.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_do;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  clear_start, mem_do,
    output cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
    output clear_busy, clear_done, mem_we, mem_addr, mem_di
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output clear_start, mem_do,
    input  cpu_rdata, cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  clear_busy, clear_done, mem_we, mem_addr, mem_di
  );

endinterface

// File: rtl/dmem_starve_cnt.sv
// Counts consecutive denied debug cycles and flags when debug must be forced onto the port.
module dmem_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic starve_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en) begin
      if (!dbg_req || dbg_gnt) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(LIMIT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign starve_c = dbg_req && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMem arbiter: clear engine > starved debug > CPU > debug.
// Zero-fill engine is built only when DMEM_ARB_CLEAR_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              in_clear;
  logic              starve_c;
  logic              cpu_gnt;
  logic              dbg_gnt;
  mem_req_t          cpu_rq, dbg_rq, mem_rq;
  logic              dbg_rvalid_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  assign in_clear = (state_q == ST_CLEAR);
  assign cpu_rq   = '{we: bus.cpu_we, addr: bus.cpu_addr, data: bus.cpu_wdata};
  assign dbg_rq   = '{we: bus.dbg_we, addr: bus.dbg_addr, data: bus.dbg_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

`ifdef DMEM_ARB_CLEAR_EN
  // Clear request is only sampled in IDLE; repeats during a fill are dropped.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE:  if (bus.clear_start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.clear_busy = in_clear;
  assign bus.clear_done = (state_q == ST_DONE);
`else
  logic unused_clear_start;

  always_comb begin
    state_d   = ST_IDLE;
    clr_idx_d = '0;
  end

  assign unused_clear_start = bus.clear_start;
  assign bus.clear_busy     = 1'b0;
  assign bus.clear_done     = 1'b0;
`endif

  dmem_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!in_clear),
    .dbg_req  (bus.dbg_req),
    .dbg_gnt  (dbg_gnt),
    .starve_c (starve_c)
  );

  // Port ownership; nothing is granted while reset is held.
  always_comb begin
    mem_rq  = '0;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (in_clear) begin
        mem_rq = '{we: 1'b1, addr: clr_idx_q, data: DATA_W'(0)};
      end else if (starve_c) begin
        mem_rq  = dbg_rq;
        dbg_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        mem_rq  = cpu_rq;
        cpu_gnt = 1'b1;
      end else if (bus.dbg_req) begin
        mem_rq  = dbg_rq;
        dbg_gnt = 1'b1;
      end
    end
  end

  // Debug read data is the word seen at grant time, so a write returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      dbg_rvalid_q <= dbg_gnt;
      if (dbg_gnt) dbg_rdata_q <= bus.mem_do;
    end
  end

  assign bus.mem_we     = mem_rq.we;
  assign bus.mem_addr   = mem_rq.addr;
  assign bus.mem_di     = mem_rq.data;
  assign bus.cpu_rdata  = bus.mem_do;
  assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;

endmodule
